// File: rtl/text_cursor_writer_if.sv
// Byte-stream input and character-buffer write port of the text cursor writer.
// The slave side is the writer itself; the master side is the byte source / observer.
interface text_cursor_writer_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 5
);
    logic [7:0]       char_i;
    logic             valid_i;
    logic             ready_o;
    logic             wr_en_o;
    logic [COL_W-1:0] col_w_o;
    logic [ROW_W-1:0] row_w_o;
    logic [6:0]       din_o;
    logic [COL_W-1:0] cursor_col_o;
    logic [ROW_W-1:0] cursor_row_o;

    modport slave (
        input  char_i, valid_i,
        output ready_o, wr_en_o, col_w_o, row_w_o, din_o, cursor_col_o, cursor_row_o
    );

    modport master (
        output char_i, valid_i,
        input  ready_o, wr_en_o, col_w_o, row_w_o, din_o, cursor_col_o, cursor_row_o
    );
endinterface

// File: rtl/text_cursor_writer.sv
// Turns a byte stream into character-buffer writes at a hardware cursor,
// handling CR/LF/BS, line and screen wrap, and blanking of rows as they are entered.
module text_cursor_writer #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int COL_W = 7,
    parameter int ROW_W = 5
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    text_cursor_writer_if.slave bus
);
    // state   | meaning
    // CLR_ALL | blank every cell row-major after reset, ready_o low
    // IDLE    | accept bytes, ready_o high
    // CLR_ROW | blank the row the cursor just entered, ready_o low
    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [6:0]       SPACE   = 7'h20;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             wr_en_q, wr_en_d;
    logic [COL_W-1:0] col_w_q, col_w_d;
    logic [ROW_W-1:0] row_w_q, row_w_d;
    logic [6:0]       din_q, din_d;
    logic [COL_W-1:0] cur_col_q, cur_col_d;
    logic [ROW_W-1:0] cur_row_q, cur_row_d;
    logic [COL_W-1:0] clr_col_q, clr_col_d;
    logic [ROW_W-1:0] clr_row_q, clr_row_d;
    logic             clr_last_q, clr_last_d;
    logic [ROW_W-1:0] row_next;
    logic [7:0]       ch;

    assign ch       = bus.char_i;
    assign row_next = (cur_row_q == ROW_MAX) ? '0 : cur_row_q + ROW_W'(1);

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        wr_en_d    = 1'b0;
        col_w_d    = col_w_q;
        row_w_d    = row_w_q;
        din_d      = din_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        clr_col_d  = clr_col_q;
        clr_row_d  = clr_row_q;
        clr_last_d = clr_last_q;
        case (state_q)
            CLR_ALL, CLR_ROW: begin
                // clr_last_q marks that the final strobe already went out
                if (clr_last_q) begin
                    state_d    = IDLE;
                    ready_d    = 1'b1;
                    clr_last_d = 1'b0;
                end else begin
                    wr_en_d = 1'b1;
                    col_w_d = clr_col_q;
                    row_w_d = clr_row_q;
                    din_d   = SPACE;
                    if (clr_col_q == COL_MAX) begin
                        clr_col_d = '0;
                        if (state_q == CLR_ROW || clr_row_q == ROW_MAX)
                            clr_last_d = 1'b1;
                        else
                            clr_row_d = clr_row_q + ROW_W'(1);
                    end else begin
                        clr_col_d = clr_col_q + COL_W'(1);
                    end
                end
            end
            IDLE: begin
                if (bus.valid_i && ready_q) begin
                    if (ch[7]) begin
                        // non-ASCII: consumed without effect
                    end else if (ch >= 8'h20 && ch <= 8'h7E) begin
                        wr_en_d = 1'b1;
                        col_w_d = cur_col_q;
                        row_w_d = cur_row_q;
                        din_d   = ch[6:0];
                        if (cur_col_q == COL_MAX) begin
                            cur_col_d  = '0;
                            cur_row_d  = row_next;
                            clr_col_d  = '0;
                            clr_row_d  = row_next;
                            clr_last_d = 1'b0;
                            state_d    = CLR_ROW;
                            ready_d    = 1'b0;
                        end else begin
                            cur_col_d = cur_col_q + COL_W'(1);
                        end
                    end else if (ch == 8'h0D) begin
                        cur_col_d = '0;
                    end else if (ch == 8'h0A) begin
                        // LF issues the first blanking strobe itself, saving a cycle
                        cur_col_d = '0;
                        cur_row_d = row_next;
                        wr_en_d   = 1'b1;
                        col_w_d   = '0;
                        row_w_d   = row_next;
                        din_d     = SPACE;
                        clr_row_d = row_next;
                        state_d   = CLR_ROW;
                        ready_d   = 1'b0;
                        if (COL_MAX == '0) begin
                            clr_col_d  = '0;
                            clr_last_d = 1'b1;
                        end else begin
                            clr_col_d  = COL_W'(1);
                            clr_last_d = 1'b0;
                        end
                    end else if (ch == 8'h08) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - COL_W'(1);
                            wr_en_d   = 1'b1;
                            col_w_d   = cur_col_q - COL_W'(1);
                            row_w_d   = cur_row_q;
                            din_d     = SPACE;
                        end
                    end
                end
            end
            default: begin
                state_d = CLR_ALL;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= CLR_ALL;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            col_w_q    <= '0;
            row_w_q    <= '0;
            din_q      <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            clr_col_q  <= '0;
            clr_row_q  <= '0;
            clr_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            col_w_q    <= col_w_d;
            row_w_q    <= row_w_d;
            din_q      <= din_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            clr_col_q  <= clr_col_d;
            clr_row_q  <= clr_row_d;
            clr_last_q <= clr_last_d;
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.wr_en_o      = wr_en_q;
    assign bus.col_w_o      = col_w_q;
    assign bus.row_w_o      = row_w_q;
    assign bus.din_o        = din_q;
    assign bus.cursor_col_o = cur_col_q;
    assign bus.cursor_row_o = cur_row_q;
endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer on a 4x3 screen: reset clear, typing,
// wraps, control characters and reset during a row clear.
module tb_text_cursor_writer;
    localparam int COLS  = 4;
    localparam int ROWS  = 3;
    localparam int COL_W = 7;
    localparam int ROW_W = 5;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    text_cursor_writer_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    text_cursor_writer #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {wr_en, col_w, row_w, din}
    task automatic check_wr(input string tag, input logic en, input int c, input int r, input int d);
        check(tag, 32'({bus.wr_en_o, bus.col_w_o, bus.row_w_o, bus.din_o}),
              32'({en, COL_W'(c), ROW_W'(r), 7'(d)}));
    endtask

    // {ready, cursor_col, cursor_row}
    task automatic check_cur(input string tag, input logic rdy, input int c, input int r);
        check(tag, 32'({bus.ready_o, bus.cursor_col_o, bus.cursor_row_o}),
              32'({rdy, COL_W'(c), ROW_W'(r)}));
    endtask

    task automatic send(input logic [7:0] c);
        bus.char_i  = c;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        bus.valid_i = 1'b0;
        bus.char_i  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_wr("reset_wr", 1'b0, 0, 0, 0);
        check_cur("reset_cur", 1'b0, 0, 0);
        rstn = 1'b1;

        for (int k = 0; k < COLS * ROWS; k++) begin
            @(negedge clk);
            check_wr("clr_all_strobe", 1'b1, k % COLS, k / COLS, 8'h20);
            check_cur("clr_all_cur", 1'b0, 0, 0);
        end
        @(negedge clk);
        check_wr("clr_all_done", 1'b0, 3, 2, 8'h20);
        check_cur("clr_all_ready", 1'b1, 0, 0);

        // back-to-back typing
        bus.char_i  = 8'h41;
        bus.valid_i = 1'b1;
        @(negedge clk);
        check_wr("b2b_A", 1'b1, 0, 0, 8'h41);
        check_cur("b2b_A_cur", 1'b1, 1, 0);
        bus.char_i = 8'h42;
        @(negedge clk);
        check_wr("b2b_B", 1'b1, 1, 0, 8'h42);
        check_cur("b2b_B_cur", 1'b1, 2, 0);
        bus.char_i = 8'h43;
        @(negedge clk);
        check_wr("b2b_C", 1'b1, 2, 0, 8'h43);
        check_cur("b2b_C_cur", 1'b1, 3, 0);
        bus.valid_i = 1'b0;

        // line wrap
        send(8'h44);
        check_wr("wrap_D", 1'b1, 3, 0, 8'h44);
        check_cur("wrap_D_cur", 1'b0, 0, 1);
        for (int k = 0; k < COLS; k++) begin
            @(negedge clk);
            check_wr("wrap_clr_row1", 1'b1, k, 1, 8'h20);
            check_cur("wrap_clr_cur", 1'b0, 0, 1);
        end
        @(negedge clk);
        check_wr("wrap_done", 1'b0, 3, 1, 8'h20);
        check_cur("wrap_ready", 1'b1, 0, 1);

        // BS at column 0 does nothing
        send(8'h08);
        check_wr("bs_col0", 1'b0, 3, 1, 8'h20);
        check_cur("bs_col0_cur", 1'b1, 0, 1);

        send(8'h45);
        check_wr("type_E", 1'b1, 0, 1, 8'h45);
        send(8'h46);
        check_wr("type_F", 1'b1, 1, 1, 8'h46);
        check_cur("at_2_1", 1'b1, 2, 1);
        send(8'h08);
        check_wr("bs_write", 1'b1, 1, 1, 8'h20);
        check_cur("bs_cur", 1'b1, 1, 1);

        send(8'h47);
        check_wr("type_G", 1'b1, 1, 1, 8'h47);
        send(8'h48);
        check_wr("type_H", 1'b1, 2, 1, 8'h48);
        check_cur("at_3_1", 1'b1, 3, 1);
        send(8'h0D);
        check_wr("cr_nowr", 1'b0, 2, 1, 8'h48);
        check_cur("cr_cur", 1'b1, 0, 1);

        send(8'h01);
        check_wr("ctl_ignored", 1'b0, 2, 1, 8'h48);
        check_cur("ctl_cur", 1'b1, 0, 1);

        // fill row 1, wrap into row 2
        send(8'h49);
        send(8'h4A);
        send(8'h4B);
        check_wr("type_K", 1'b1, 2, 1, 8'h4B);
        send(8'h4C);
        check_wr("type_L", 1'b1, 3, 1, 8'h4C);
        check_cur("wrap2_cur", 1'b0, 0, 2);
        for (int k = 0; k < COLS; k++) begin
            @(negedge clk);
            check_wr("wrap_clr_row2", 1'b1, k, 2, 8'h20);
        end
        @(negedge clk);
        check_cur("wrap2_ready", 1'b1, 0, 2);

        send(8'h4D);
        send(8'h4E);
        check_wr("type_N", 1'b1, 1, 2, 8'h4E);
        check_cur("at_2_2", 1'b1, 2, 2);

        // LF on the last row wraps to row 0, clearing starts at once
        send(8'h0A);
        check_wr("lf_clr0", 1'b1, 0, 0, 8'h20);
        check_cur("lf_cur", 1'b0, 0, 0);
        for (int k = 1; k < COLS; k++) begin
            @(negedge clk);
            check_wr("lf_clr_row0", 1'b1, k, 0, 8'h20);
        end
        @(negedge clk);
        check_wr("lf_done", 1'b0, 3, 0, 8'h20);
        check_cur("lf_ready", 1'b1, 0, 0);

        send(8'h9B);
        check_wr("nonascii_nowr", 1'b0, 3, 0, 8'h20);
        check_cur("nonascii_cur", 1'b1, 0, 0);
        send(8'h7F);
        check_wr("del_ignored", 1'b0, 3, 0, 8'h20);
        check_cur("del_cur", 1'b1, 0, 0);

        // reset during the second strobe of a row clear
        send(8'h0A);
        check_wr("lf2_s1", 1'b1, 0, 1, 8'h20);
        check_cur("lf2_cur", 1'b0, 0, 1);
        @(negedge clk);
        check_wr("lf2_s2", 1'b1, 1, 1, 8'h20);
        rstn = 1'b0;
        @(negedge clk);
        check_wr("midrst_wr", 1'b0, 0, 0, 0);
        check_cur("midrst_cur", 1'b0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);
        check_wr("restart_s1", 1'b1, 0, 0, 8'h20);
        @(negedge clk);
        check_wr("restart_s2", 1'b1, 1, 0, 8'h20);
        check_cur("restart_cur", 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream feeder of the character buffer (7-bit char cells addressed by column/row).
- Accepts a byte stream (e.g. from a UART receiver) over valid/ready and writes printable characters at a hardware cursor.
- Handles CR, LF and BS, wraps at end of line and end of screen, and blanks rows as the cursor enters them.
- Drives the buffer's write port directly: wr_en, col_w, row_w, din.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- COL_W, 7, column address width (>= clog2(COLS)).
- ROW_W, 5, row address width (>= clog2(ROWS)).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, synchronous, active-low.
- char_i  in  8  incoming byte.
- valid_i  in  1  char_i valid.
- ready_o  out  1  block can accept a byte this cycle.
- wr_en_o  out  1  buffer write strobe.
- col_w_o  out  COL_W  buffer write column.
- row_w_o  out  ROW_W  buffer write row.
- din_o  out  7  buffer write data (char code).
- cursor_col_o  out  COL_W  current cursor column.
- cursor_row_o  out  ROW_W  current cursor row.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rstn_i.
- Registered outputs: all outputs are registered.
- Reset values: ready_o=0, wr_en_o=0, col_w_o=0, row_w_o=0, din_o=0, cursor_col_o=0, cursor_row_o=0. State=CLR_ALL, clear counter=0.
- Reset mid-operation: rstn_i low at any edge aborts any clear or write. Next edge applies the reset values. CLR_ALL restarts from cell (0,0).
- States: CLR_ALL, IDLE, CLR_ROW. ready_o=1 only in IDLE, and is registered so it is valid in the same cycle as the state.
- CLR_ALL:
  - One write per cycle, row-major (0,0),(1,0)..(COLS-1,ROWS-1). wr_en_o=1, din_o=0x20.
  - First strobe occurs in the first cycle after rstn_i goes high.
  - After COLS*ROWS strobes, go to IDLE. Cursor stays at (0,0).
- Handshake: a byte is accepted at edge N when valid_i && ready_o. Its buffer write, if any, appears as wr_en_o=1 in cycle N+1. The cursor update is visible in cycle N+1.
- Bytes with char_i[7]=1: accepted, no write, no cursor change.
- Printable 0x20..0x7E: write char_i[6:0] at the old cursor position.
  - If old col < COLS-1: col+1, stay in IDLE. Back-to-back accepts are allowed every cycle.
  - If old col = COLS-1: col=0, row=(row+1) mod ROWS, enter CLR_ROW for the new row.
- 0x0D (CR): col=0, no write, stay in IDLE.
- 0x0A (LF): col=0, row=(row+1) mod ROWS, no char write. Enter CLR_ROW.
- 0x08 (BS):
  - If col>0: col-1 and write 0x20 at (col-1,row).
  - If col=0: no-op, no line-up.
- Other bytes 0x00..0x1F and 0x7F: accepted and ignored.
- CLR_ROW:
  - COLS strobes of 0x20 at (0..COLS-1, new row), one per cycle, with ready_o=0.
  - First clear strobe occurs in the cycle after the triggering write cycle for a wrap, or in cycle N+1 for LF.
  - Return to IDLE after the last strobe.
- wr_en_o=0 in any cycle with no write. col_w_o, row_w_o and din_o hold their last value when wr_en_o=0.
- Wrap: row ROWS-1 goes to row 0. No scrolling; the old row 0 is blanked by CLR_ROW.
- Arithmetic: column and row counters compare against COLS-1 and ROWS-1 explicitly, with no reliance on power-of-two overflow.

Test Plan (COLS=4, ROWS=3 unless noted):
- Reset: hold rstn_i=0 for 3 cycles, then release -> exactly 12 strobes of din 0x20 at (0,0)..(3,2) in order. ready_o rises in the 13th cycle after release. Cursor reads (0,0).
- Back-to-back: valid_i held with 'A','B','C' (0x41..0x43) -> strobes at (0,0),(1,0),(2,0) on consecutive cycles. Cursor ends at (3,0). ready_o stays 1.
- Line wrap: from (3,0) send 'D' -> write 0x44 at (3,0), then 4 strobes of 0x20 on row 1 with ready_o=0. Cursor is (0,1).
- Screen wrap and LF: cursor (2,2), send 0x0A -> cursor (0,0), row 0 cleared with 4 strobes, no char write.
- BS and CR: at (2,1), BS -> 0x20 written at (1,1), cursor (1,1). At (0,1), BS -> no strobe. CR at (3,1) -> cursor (0,1), no strobe.
- Mid-clear reset and non-ASCII: assert rstn_i=0 during the 2nd strobe of CLR_ROW -> outputs reset next edge, and CLR_ALL restarts at (0,0). Byte 0x9B -> accepted, no strobe, cursor unchanged.
